io_out_stream: RTL and testbench
================================

Name: io_out_stream

Overview:
- Downstream output stage of the fixed-point processor. It consumes the processor's output-port write strobes (io_out, addr_out, out_en).
- Keeps one latched register per output address and pulses a per-address strobe on each write.
- Writes to one designated stream address also go into a FIFO. The FIFO presents them to a downstream consumer through a valid/ready handshake.
- The processor cannot be stalled, so a write into a full FIFO is dropped and flagged.

Parameters:
- NUBITS, 16, data word width (equals processor word width)
- NUIOOU, 2, number of output addresses
- FDEPTH, 8, FIFO depth in words; power of 2, at least 2
- SADDR, 0, output address routed into the FIFO; must be below NUIOOU
- FDEPTW, $clog2(FDEPTH), internal pointer width

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous active-low reset
- io_out  input  NUBITS  processor output data
- addr_out  input  $clog2(NUIOOU)  processor output address
- out_en  input  1  processor output write strobe, one cycle per write
- out_reg  output  NUIOOU*NUBITS  latched port values; address k occupies bits [k*NUBITS +: NUBITS]
- out_strb  output  NUIOOU  one-cycle pulse per address written
- m_data  output  NUBITS  FIFO head word
- m_valid  output  1  FIFO non-empty
- m_ready  input  1  consumer accepts head word
- level  output  FDEPTW+1  current FIFO occupancy, 0..FDEPTH
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears ovf

Behaviour:
- Reset (rst=0, asynchronous): out_reg=0, out_strb=0, FIFO empty (read/write pointers and count = 0), m_valid=0, m_data=0, level=0, ovf=0. Reset asserted mid-stream discards FIFO contents immediately.
- Write capture: when out_en=1 and addr_out=k<NUIOOU at rising edge N:
  - out_reg slice k takes io_out after edge N.
  - out_strb[k]=1 for exactly the cycle after edge N.
  - Only one bit of out_strb is high at a time.
- Invalid address: addr_out>=NUIOOU with out_en=1 is ignored. No register update, no strobe, no push.
- Push: a write to addr_out=SADDR also pushes io_out into the FIFO at the same edge.
- FIFO is first-word-fall-through:
  - m_data always shows the word at the read pointer.
  - m_valid=(count!=0).
  - A word pushed at edge N is visible on m_data/m_valid after edge N (latency 1 cycle).
- Pop: m_valid=1 and m_ready=1 at an edge removes the head. m_ready while empty has no effect.
- Pointers wrap modulo FDEPTH. level equals the registered count.
- Simultaneous push and pop when not empty: both occur and count is unchanged.
- Push when count=FDEPTH without a pop: word dropped, contents unchanged, ovf set to 1 after that edge.
- Push when count=FDEPTH with a pop at the same edge: push accepted, count stays FDEPTH, no overflow.
- ovf_clr=1 clears ovf at the next edge. If an overflow occurs at the same edge, set wins (ovf=1).
- m_data when empty holds the last-read word. It is don't-care; the bench must not check it.
- All outputs are registered. There is no combinational path from inputs to outputs except m_data selection by the registered read pointer.

Test Plan:
- Reset then idle: all outputs 0. Assert rst=0 mid-run with level=3: level=0, m_valid=0 immediately, without waiting for a clock edge.
- Register and strobe: write 0x1234 to addr 1, then 0xBEEF to addr 0 (SADDR=0).
  - out_reg = {0x1234, 0xBEEF}.
  - out_strb = 2'b10 then 2'b01, one cycle each.
  - FIFO holds only 0xBEEF.
  - An out_en with addr_out=2 on NUIOOU=2 changes nothing.
- Ordering with m_ready=0: push 1..8 to SADDR, giving level=8 and m_data=1. Raise m_ready: consumer receives 1,2,...,8 in order and m_valid drops after the 8th.
- Overflow: with level=8 and m_ready=0, push 9. Required: ovf=1, level=8, drained sequence is 1..8 (9 lost). Pulse ovf_clr: ovf=0.
- Full plus simultaneous pop: with level=8, push 9 while m_ready=1. Required: ovf stays 0, level stays 8, drained sequence is 2..9.
- Throughput and wrap: push every cycle with m_ready=1 continuously for 20 words. Required: level stays at most 1, all 20 words are received in order with 1-cycle latency, and pointers wrap with no loss or duplication.

Source files
------------

// File: rtl/io_out_stream.sv
// Output stage of the fixed-point processor: per-address latched registers with write strobes,
// plus a first-word-fall-through FIFO fed by writes to the stream address.
module io_out_stream #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8,
    parameter int SADDR  = 0,
    parameter int FDEPTW = $clog2(FDEPTH),
    localparam int AW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [AW-1:0]            addr_out,
    input  logic                     out_en,
    output logic [NUIOOU*NUBITS-1:0] out_reg,
    output logic [NUIOOU-1:0]        out_strb,
    output logic [NUBITS-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [FDEPTW:0]          level,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    // Handshake: a word moves on every rising edge where m_valid and m_ready are both high;
    // m_valid never depends on m_ready, and m_data is stable while m_valid is held.

    logic [NUIOOU*NUBITS-1:0] out_reg_q, out_reg_d;
    logic [NUIOOU-1:0]        out_strb_q, out_strb_d;
    logic [NUBITS-1:0]        mem_q [FDEPTH];
    logic [NUBITS-1:0]        mem_d [FDEPTH];
    logic [FDEPTW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FDEPTW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FDEPTW:0]          count_q, count_d;
    logic                     ovf_q, ovf_d;

    logic [AW:0] addr_ext;
    logic        wr_ok;
    logic        push;
    logic        pop;
    logic        full;
    logic        push_acc;
    logic        ovf_set;

    // One extra address bit so the range check is meaningful even when NUIOOU is a power of 2.
    assign addr_ext = {1'b0, addr_out};
    assign wr_ok    = out_en && (addr_ext < (AW+1)'(NUIOOU));
    assign push     = wr_ok && (addr_ext == (AW+1)'(SADDR));
    assign pop      = (count_q != '0) && m_ready;
    assign full     = (count_q == (FDEPTW+1)'(FDEPTH));
    // A pop at the same edge frees the slot, so a full FIFO can still accept the push.
    assign push_acc = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    always_comb begin
        out_reg_d  = out_reg_q;
        out_strb_d = '0;
        for (int k = 0; k < NUIOOU; k++) begin
            if (wr_ok && (addr_ext == (AW+1)'(k))) begin
                out_reg_d[k*NUBITS +: NUBITS] = io_out;
                out_strb_d[k]                 = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = io_out;
            wr_ptr_d        = wr_ptr_q + FDEPTW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FDEPTW'(1);
        end
        count_d = count_q + (FDEPTW+1)'(push_acc) - (FDEPTW+1)'(pop);
        ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg_q  <= '0;
            out_strb_q <= '0;
            for (int i = 0; i < FDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            out_reg_q  <= out_reg_d;
            out_strb_q <= out_strb_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_reg  = out_reg_q;
    assign out_strb = out_strb_q;
    assign m_data   = mem_q[rd_ptr_q];
    assign m_valid  = (count_q != '0);
    assign level    = count_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_io_out_stream.sv
// Bench for io_out_stream: directed writes, FIFO words checked by a scoreboard monitor,
// plus a second instance with three addresses to exercise an out-of-range address.
module tb_io_out_stream;

    logic        clk;
    logic        rst;
    logic [15:0] io_out;
    logic [0:0]  addr_out;
    logic        out_en;
    logic [31:0] out_reg;
    logic [1:0]  out_strb;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  level;
    logic        ovf;
    logic        ovf_clr;

    logic [15:0] d3_io;
    logic [1:0]  d3_addr;
    logic        d3_en;
    logic [47:0] d3_out_reg;
    logic [2:0]  d3_strb;
    logic [15:0] d3_m_data;
    logic        d3_m_valid;
    logic [3:0]  d3_level;
    logic        d3_ovf;

    int tests;
    int fails;
    int rx_cnt;
    logic thr_chk;
    logic [15:0] exp_q[$];

    io_out_stream dut (
        .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
        .out_reg(out_reg), .out_strb(out_strb), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    io_out_stream #(.NUIOOU(3)) dut3 (
        .clk(clk), .rst(rst), .io_out(d3_io), .addr_out(d3_addr), .out_en(d3_en),
        .out_reg(d3_out_reg), .out_strb(d3_strb), .m_data(d3_m_data), .m_valid(d3_m_valid),
        .m_ready(1'b0), .level(d3_level), .ovf(d3_ovf), .ovf_clr(1'b0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: all input changes happen 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [0:0] a, input logic [15:0] d, input logic exp_push);
        out_en   = 1'b1;
        addr_out = a;
        io_out   = d;
        if (exp_push) exp_q.push_back(d);
        step();
        out_en = 1'b0;
    endtask

    // scoreboard monitor: compares every word the consumer accepts
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL drain_unexpected: got %0h expected none", m_data);
            end else begin
                chk("drain_data", m_data, exp_q.pop_front());
            end
        end
        if (thr_chk) begin
            chk("thr_level", level, 1);
            chk("thr_valid", m_valid, 1);
        end
    end

    initial begin
        tests = 0; fails = 0; rx_cnt = 0; thr_chk = 1'b0;
        io_out = '0; addr_out = '0; out_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        d3_io = '0; d3_addr = '0; d3_en = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_reg", out_reg, 0);
        chk("rst_strb", out_strb, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        step();

        // register and strobe
        wr(1'b1, 16'h1234, 1'b0);
        @(negedge clk);
        chk("strb_a1", out_strb, 2'b10);
        chk("reg_a1", out_reg, 32'h1234_0000);
        chk("level_a1", level, 0);
        step();
        wr(1'b0, 16'hBEEF, 1'b1);
        @(negedge clk);
        chk("strb_a0", out_strb, 2'b01);
        chk("reg_both", out_reg, 32'h1234_BEEF);
        chk("level_a0", level, 1);
        chk("head_a0", m_data, 16'hBEEF);
        step();
        @(negedge clk);
        chk("strb_clear", out_strb, 0);
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain1_level", level, 0);
        chk("drain1_valid", m_valid, 0);
        step();

        // invalid address on a three-address instance
        d3_en = 1'b1; d3_addr = 2'd3; d3_io = 16'hFFFF;
        step();
        d3_en = 1'b0;
        @(negedge clk);
        chk("inv_reg", d3_out_reg, 0);
        chk("inv_strb", d3_strb, 0);
        chk("inv_level", d3_level, 0);
        step();
        d3_en = 1'b1; d3_addr = 2'd2; d3_io = 16'h5555;
        step();
        d3_en = 1'b0;
        @(negedge clk);
        chk("a2_reg", d3_out_reg, 48'h5555_0000_0000);
        chk("a2_strb", d3_strb, 3'b100);
        step();

        // ordering with consumer stalled, then overflow
        for (int i = 1; i <= 8; i++) wr(1'b0, 16'(i), 1'b1);
        @(negedge clk);
        chk("fill_level", level, 8);
        chk("fill_head", m_data, 1);
        chk("fill_valid", m_valid, 1);
        step();
        wr(1'b0, 16'd9, 1'b0);
        @(negedge clk);
        chk("ovf_set", ovf, 1);
        chk("ovf_level", level, 8);
        chk("ovf_head", m_data, 1);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", ovf, 0);
        step();
        m_ready = 1'b1;
        repeat (8) step();
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain8_level", level, 0);
        chk("drain8_valid", m_valid, 0);
        chk("drain8_sb", exp_q.size(), 0);
        step();

        // full with simultaneous pop
        for (int i = 1; i <= 8; i++) wr(1'b0, 16'(i), 1'b1);
        m_ready = 1'b1;
        wr(1'b0, 16'd9, 1'b1);
        m_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_ovf", ovf, 0);
        chk("fullpop_level", level, 8);
        chk("fullpop_head", m_data, 2);
        step();
        m_ready = 1'b1;
        repeat (8) step();
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain9_level", level, 0);
        chk("drain9_sb", exp_q.size(), 0);
        step();

        // throughput and pointer wrap
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(1'b0, 16'hA000 + 16'(i), 1'b1);
            thr_chk = 1'b1;
        end
        @(negedge clk);
        thr_chk = 1'b0;
        step();
        m_ready = 1'b0;
        @(negedge clk);
        chk("thr_end_level", level, 0);
        chk("thr_sb", exp_q.size(), 0);
        chk("rx_total", rx_cnt, 38);
        step();

        // asynchronous reset with words queued
        for (int i = 0; i < 3; i++) wr(1'b0, 16'h0C00 + 16'(i), 1'b0);
        @(negedge clk);
        chk("pre_rst_level", level, 3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_reg", out_reg, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_level", level, 0);
        chk("post_rst_ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
